if_inst_queue: RTL and testbench

Instruction queue on the consumer side of the IF stage in the ARM pipeline. It accepts the `pc`/`Instruction` pair the IF stage presents each cycle, buffers up to DEPTH fetched words in order, and hands them to the ID stage. When the buffer is full it raises `freeze` back to IF so the PC holds. A taken branch from EXE flushes the queue and discards the word fetched in that cycle.

---
 rtl/if_inst_queue.sv | 101 ++++++++++
 tb/tb_if_inst_queue.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/if_inst_queue.sv
// In-order instruction buffer between IF and ID; flush discards all entries and the current word.
// Optional IFQ_PERF_EN adds saturating freeze-cycle and flushed-word counters.
module if_inst_queue #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [31:0]   pc_in,
  input  logic [31:0]   instruction_in,
  input  logic          flush,
  input  logic          id_stall,
  output logic          freeze,
  output logic          id_valid,
  output logic [31:0]   id_pc,
  output logic [31:0]   id_instruction,
  output logic [CW-1:0] count
`ifdef IFQ_PERF_EN
  ,
  output logic [15:0]   perf_freeze_cycles,
  output logic [15:0]   perf_flushed_words
`endif
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [63:0]   r_mem [DEPTH];
  logic [AW-1:0] r_rd_ptr;
  logic [AW-1:0] r_wr_ptr;
  logic [CW-1:0] r_count;
  logic [CW-1:0] w_count_d;
  logic          w_push;
  logic          w_pop;

  // Full blocks the push even when a pop frees a slot in the same cycle.
  assign freeze   = (r_count == CW'(DEPTH));
  assign id_valid = (r_count != '0);
  assign w_push   = !freeze && !flush;
  assign w_pop    = id_valid && !id_stall && !flush;
  assign count    = r_count;

  assign {id_pc, id_instruction} = id_valid ? r_mem[r_rd_ptr] : 64'd0;

  always_comb begin
    w_count_d = r_count;
    if (w_push && !w_pop) begin
      w_count_d = r_count + CW'(1);
    end else if (!w_push && w_pop) begin
      w_count_d = r_count - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_count  <= '0;
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (flush) begin
      r_count  <= '0;
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= {pc_in, instruction_in};
        r_wr_ptr        <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      r_count <= w_count_d;
    end
  end

`ifdef IFQ_PERF_EN
  logic [15:0] r_perf_fc;
  logic [15:0] r_perf_fw;
  logic [16:0] w_fw_sum;

  assign w_fw_sum           = {1'b0, r_perf_fw} + 17'(r_count);
  assign perf_freeze_cycles = r_perf_fc;
  assign perf_flushed_words = r_perf_fw;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_perf_fc <= '0;
      r_perf_fw <= '0;
    end else begin
      if (freeze && (r_perf_fc != 16'hFFFF)) begin
        r_perf_fc <= r_perf_fc + 16'd1;
      end
      if (flush) begin
        r_perf_fw <= w_fw_sum[16] ? 16'hFFFF : w_fw_sum[15:0];
      end
    end
  end
`endif

endmodule

// File: tb/tb_if_inst_queue.sv
// Bench for if_inst_queue: queue-based reference model checked every negedge plus directed
// literal checks for reset, streaming, fill/drain, flush, wrap and (IFQ_PERF_EN) perf counters.
module tb_if_inst_queue;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned CW    = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [31:0]   pc_in = '0;
  logic [31:0]   instruction_in = '0;
  logic          flush = 1'b0;
  logic          id_stall = 1'b0;
  logic          freeze;
  logic          id_valid;
  logic [31:0]   id_pc;
  logic [31:0]   id_instruction;
  logic [CW-1:0] count;
`ifdef IFQ_PERF_EN
  logic [15:0]   perf_freeze_cycles;
  logic [15:0]   perf_flushed_words;
`endif

  if_inst_queue #(.DEPTH(DEPTH), .CW(CW)) dut (
    .clk            (clk),
    .rst            (rst),
    .pc_in          (pc_in),
    .instruction_in (instruction_in),
    .flush          (flush),
    .id_stall       (id_stall),
    .freeze         (freeze),
    .id_valid       (id_valid),
    .id_pc          (id_pc),
    .id_instruction (id_instruction),
    .count          (count)
`ifdef IFQ_PERF_EN
    ,
    .perf_freeze_cycles (perf_freeze_cycles),
    .perf_flushed_words (perf_flushed_words)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model: a plain FIFO of {pc, instr} words plus the fetching PC of IF.
  logic [63:0]  mq[$];
  logic [31:0]  if_pc = '0;
  bit           chk_en = 1'b0;
  bit           watch16 = 1'b0;
  int unsigned  m_pfc = 0;
  int unsigned  m_pfw = 0;
  logic [31:0]  e_pc;
  logic [31:0]  e_in;
  logic [31:0]  got_drain [5];
  logic [31:0]  exp_drain [5] = '{32'd0, 32'd4, 32'd8, 32'd12, 32'd16};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] instr_of(input logic [31:0] pc);
    return 32'hE280_0000 | (pc >> 2);
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      e_pc = (mq.size() != 0) ? mq[0][63:32] : 32'd0;
      e_in = (mq.size() != 0) ? mq[0][31:0] : 32'd0;
      chk("count", 32'(count), mq.size());
      chk("freeze", 32'(freeze), 32'(mq.size() == DEPTH));
      chk("id_valid", 32'(id_valid), 32'(mq.size() != 0));
      chk("id_pc", id_pc, e_pc);
      chk("id_instruction", id_instruction, e_in);
      if (watch16) chk("word16_gone", 32'(id_valid && (id_pc == 32'd16)), 32'd0);
`ifdef IFQ_PERF_EN
      chk("perf_freeze_cycles", 32'(perf_freeze_cycles), m_pfc);
      chk("perf_flushed_words", 32'(perf_flushed_words), m_pfw);
`endif
    end
  end

  // One clock of IF/ID activity; model advances on the same edge as the DUT.
  task automatic cycle(input logic stall, input logic fl, input logic [31:0] target);
    bit mf;
    bit mv;
    id_stall       = stall;
    flush          = fl;
    pc_in          = if_pc;
    instruction_in = instr_of(if_pc);
    @(posedge clk);
    mf = (mq.size() == DEPTH);
    mv = (mq.size() != 0);
    if (mf && m_pfc < 65535) m_pfc++;
    if (fl) begin
      m_pfw = (m_pfw + mq.size() > 65535) ? 65535 : m_pfw + mq.size();
      mq.delete();
      if_pc = target;
    end else begin
      if (mv && !stall) void'(mq.pop_front());
      if (!mf) begin
        mq.push_back({pc_in, instruction_in});
        if_pc = if_pc + 32'd4;
      end
    end
    #1;
  endtask

  // Asynchronous reset asserted between edges; outputs must clear without a clock.
  task automatic do_reset();
    #2 rst = 1'b0;
    #1;
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_id_valid", 32'(id_valid), 32'd0);
    chk("rst_id_pc", id_pc, 32'd0);
    chk("rst_freeze", 32'(freeze), 32'd0);
    mq.delete();
    if_pc   = '0;
    m_pfc   = 0;
    m_pfw   = 0;
    watch16 = 1'b0;
    flush   = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
  endtask

  initial begin
    do_reset();
    chk_en = 1'b1;

    // Mid-run reset with three words held.
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 32'd0);
    chk("pre_rst_count", 32'(count), 32'd3);
    do_reset();

    // Fill and drain.
    for (int i = 0; i < 6; i++) cycle(1'b1, 1'b0, 32'd0);
    chk("fill_count", 32'(count), 32'd4);
    chk("fill_freeze", 32'(freeze), 32'd1);
    chk("fill_pc_held", pc_in, 32'd16);
    for (int i = 0; i < 5; i++) begin
      got_drain[i] = id_pc;
      if (i == 1) chk("freeze_after_pop", 32'(freeze), 32'd0);
      cycle(1'b0, 1'b0, 32'd0);
    end
    for (int i = 0; i < 5; i++) chk("drain_order", got_drain[i], exp_drain[i]);

    // Streaming.
    do_reset();
    cycle(1'b0, 1'b0, 32'd0);
    for (int i = 0; i < 8; i++) begin
      chk("stream_count", 32'(count), 32'd1);
      chk("stream_pc", id_pc, 32'(4 * i));
      cycle(1'b0, 1'b0, 32'd0);
    end

    // Flush on a full queue while pc_in = 16.
    do_reset();
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 32'd0);
    chk("preflush_pc_in", pc_in, 32'd16);
    cycle(1'b1, 1'b1, 32'h100);
    watch16 = 1'b1;
    chk("flush_count", 32'(count), 32'd0);
    chk("flush_id_valid", 32'(id_valid), 32'd0);
    chk("flush_freeze", 32'(freeze), 32'd0);
    cycle(1'b0, 1'b0, 32'd0);
    chk("target_id_pc", id_pc, 32'h100);
    chk("target_id_instr", id_instruction, 32'hE280_0040);
    for (int i = 0; i < 6; i++) cycle(1'b0, 1'b0, 32'd0);
    watch16 = 1'b0;

    // Wrap with occupancy held at 2.
    do_reset();
    cycle(1'b1, 1'b0, 32'd0);
    cycle(1'b1, 1'b0, 32'd0);
    for (int i = 0; i < 20; i++) begin
      cycle(1'b0, 1'b0, 32'd0);
      chk("wrap_count", 32'(count), 32'd2);
      chk("wrap_pc", id_pc, 32'(4 * (i + 1)));
    end
    for (int i = 0; i < 12; i++) cycle(logic'(i % 2), 1'b0, 32'd0);

`ifdef IFQ_PERF_EN
    // Two full edges plus the flush edge at count 4.
    do_reset();
    for (int i = 0; i < 6; i++) cycle(1'b1, 1'b0, 32'd0);
    cycle(1'b1, 1'b1, 32'h200);
    chk("perf_fc_lit", 32'(perf_freeze_cycles), 32'd3);
    chk("perf_fw_lit", 32'(perf_flushed_words), 32'd4);
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 32'd0);
`endif

    @(negedge clk);
    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
